// File: rtl/vend_controller.sv
// vend_controller: nickel-unit vending FSM with credit tracking, change return and registered outputs
module vend_controller #(
    parameter int PRICE      = 4,
    parameter int MAX_CREDIT = 31,
    parameter int CW         = 5
) (
    input  logic          clk,
    input  logic          reset,
    input  logic [1:0]    coin,
    input  logic          vend_req,
    input  logic          cancel,
    input  logic          dispense_ack,
    input  logic          change_ack,
    output logic          dispense,
    output logic          change_out,
    output logic          coin_reject,
    output logic          vend_done,
    output logic [CW-1:0] credit,
    output logic          busy
);
    typedef enum logic [1:0] {IDLE, DISPENSE, CHANGE} state_t;
    state_t        state_q;
    logic [CW-1:0] credit_q;
    logic          dispense_q, change_q, reject_q, done_q, busy_q;
    logic [CW:0]   coin_val, sum, eff;
    logic          coin_ok;
    always_comb begin
        coin_val = (coin == 2'b11) ? (CW+1)'(5) : (CW+1)'(coin);
        sum      = {1'b0, credit_q} + coin_val;
        coin_ok  = sum <= (CW+1)'(MAX_CREDIT);
        eff      = coin_ok ? sum : {1'b0, credit_q};
    end
    always_ff @(posedge clk) begin
        if (!reset) begin
            state_q    <= IDLE;
            credit_q   <= '0;
            dispense_q <= 1'b0;
            change_q   <= 1'b0;
            reject_q   <= 1'b0;
            done_q     <= 1'b0;
            busy_q     <= 1'b0;
        end else begin
            done_q   <= 1'b0;
            reject_q <= (coin != 2'b00) && (state_q != IDLE || !coin_ok);
            case (state_q)
                IDLE: begin
                    if (cancel && eff != '0) begin
                        credit_q <= CW'(eff);
                        state_q  <= CHANGE;
                        change_q <= 1'b1;
                        busy_q   <= 1'b1;
                    end else if (vend_req && eff >= (CW+1)'(PRICE)) begin
                        credit_q   <= CW'(eff - (CW+1)'(PRICE));
                        state_q    <= DISPENSE;
                        dispense_q <= 1'b1;
                        busy_q     <= 1'b1;
                    end else begin
                        credit_q <= CW'(eff);
                    end
                end
                DISPENSE: begin
                    if (dispense_ack) begin
                        dispense_q <= 1'b0;
                        done_q     <= 1'b1;
                        state_q    <= (credit_q != '0) ? CHANGE : IDLE;
                        change_q   <= credit_q != '0;
                        busy_q     <= credit_q != '0;
                    end
                end
                CHANGE: begin
                    if (change_ack) begin
                        credit_q <= credit_q - CW'(1);
                        if (credit_q == CW'(1)) begin
                            state_q  <= IDLE;
                            change_q <= 1'b0;
                            busy_q   <= 1'b0;
                        end
                    end
                end
                default: begin
                    state_q  <= IDLE;
                    busy_q   <= 1'b0;
                end
            endcase
        end
    end
    assign dispense    = dispense_q;
    assign change_out  = change_q;
    assign coin_reject = reject_q;
    assign vend_done   = done_q;
    assign credit      = credit_q;
    assign busy        = busy_q;
endmodule

// File: tb/tb_vend_controller.sv
// tb_vend_controller: table-driven directed checks of the vending controller plus reset-mid-operation sequences
module tb_vend_controller;
    logic       clk = 1'b0;
    logic       reset = 1'b0;
    logic [1:0] coin = 2'b00;
    logic       vend_req = 1'b0, cancel = 1'b0, dispense_ack = 1'b0, change_ack = 1'b0;
    logic       dispense, change_out, coin_reject, vend_done, busy;
    logic [4:0] credit;
    int         errors = 0;
    int         checks = 0;

    vend_controller dut (
        .clk(clk), .reset(reset), .coin(coin), .vend_req(vend_req), .cancel(cancel),
        .dispense_ack(dispense_ack), .change_ack(change_ack), .dispense(dispense),
        .change_out(change_out), .coin_reject(coin_reject), .vend_done(vend_done),
        .credit(credit), .busy(busy)
    );

    always #5 clk = ~clk;

    // exp = {credit, dispense, change_out, coin_reject, vend_done, busy}
    typedef struct packed {
        logic       rst_n;
        logic [1:0] coin;
        logic       vr, cn, da, ca;
        logic [9:0] exp;
    } vec_t;

    vec_t vecs[$];

    function automatic vec_t mk(logic r, logic [1:0] c, logic vr, logic cn, logic da, logic ca,
                                logic [4:0] cr, logic d, logic ch, logic rj, logic dn, logic b);
        vec_t v;
        v.rst_n = r; v.coin = c; v.vr = vr; v.cn = cn; v.da = da; v.ca = ca;
        v.exp = {cr, d, ch, rj, dn, b};
        return v;
    endfunction

    task automatic apply(input vec_t v, input string name);
        logic [9:0] got;
        @(negedge clk);
        reset = v.rst_n; coin = v.coin; vend_req = v.vr; cancel = v.cn;
        dispense_ack = v.da; change_ack = v.ca;
        @(posedge clk);
        #1;
        got = {credit, dispense, change_out, coin_reject, vend_done, busy};
        checks++;
        if (got !== v.exp) begin
            errors++;
            $display("FAIL %s: got credit=%0d d/c/rj/dn/b=%b, want credit=%0d d/c/rj/dn/b=%b",
                     name, got[9:5], got[4:0], v.exp[9:5], v.exp[4:0]);
        end
    endtask

    initial begin
        //            rst coin vr cn da ca  cr disp chg rej done busy
        vecs.push_back(mk(0, 2'd0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0)); // reset
        vecs.push_back(mk(1, 2'd0, 0, 1, 0, 0, 0, 0, 0, 0, 0, 0)); // cancel at zero credit
        vecs.push_back(mk(1, 2'd0, 0, 0, 1, 1, 0, 0, 0, 0, 0, 0)); // stray acks in IDLE
        vecs.push_back(mk(1, 2'd1, 0, 0, 0, 0, 1, 0, 0, 0, 0, 0)); // exact payment
        vecs.push_back(mk(1, 2'd1, 0, 0, 0, 0, 2, 0, 0, 0, 0, 0));
        vecs.push_back(mk(1, 2'd1, 0, 0, 0, 0, 3, 0, 0, 0, 0, 0));
        vecs.push_back(mk(1, 2'd1, 0, 0, 0, 0, 4, 0, 0, 0, 0, 0));
        vecs.push_back(mk(1, 2'd0, 1, 0, 0, 0, 0, 1, 0, 0, 0, 1));
        vecs.push_back(mk(1, 2'd0, 0, 1, 0, 1, 0, 1, 0, 0, 0, 1)); // cancel/change_ack ignored
        vecs.push_back(mk(1, 2'd0, 0, 0, 1, 0, 0, 0, 0, 0, 1, 0));
        vecs.push_back(mk(1, 2'd0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0));
        vecs.push_back(mk(1, 2'd3, 0, 0, 0, 0, 5, 0, 0, 0, 0, 0)); // payment with change
        vecs.push_back(mk(1, 2'd0, 1, 0, 0, 0, 1, 1, 0, 0, 0, 1));
        vecs.push_back(mk(1, 2'd2, 0, 0, 0, 0, 1, 1, 0, 1, 0, 1)); // coin refused in DISPENSE
        vecs.push_back(mk(1, 2'd0, 0, 0, 1, 0, 1, 0, 1, 0, 1, 1));
        vecs.push_back(mk(1, 2'd0, 0, 0, 0, 0, 1, 0, 1, 0, 0, 1));
        vecs.push_back(mk(1, 2'd0, 0, 0, 0, 0, 1, 0, 1, 0, 0, 1));
        vecs.push_back(mk(1, 2'd1, 0, 0, 0, 0, 1, 0, 1, 1, 0, 1)); // coin refused in CHANGE
        vecs.push_back(mk(1, 2'd0, 0, 0, 0, 1, 0, 0, 0, 0, 0, 0));
        for (int i = 1; i <= 6; i++)                               // overflow
            vecs.push_back(mk(1, 2'd3, 0, 0, 0, 0, 5'(5 * i), 0, 0, 0, 0, 0));
        vecs.push_back(mk(1, 2'd2, 0, 0, 0, 0, 30, 0, 0, 1, 0, 0));
        vecs.push_back(mk(1, 2'd0, 0, 0, 0, 0, 30, 0, 0, 0, 0, 0));
        vecs.push_back(mk(1, 2'd1, 0, 0, 0, 0, 31, 0, 0, 0, 0, 0));
        vecs.push_back(mk(1, 2'd3, 0, 0, 0, 0, 31, 0, 0, 1, 0, 0));
        vecs.push_back(mk(0, 2'd0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0));
        vecs.push_back(mk(1, 2'd1, 0, 0, 0, 0, 1, 0, 0, 0, 0, 0)); // underpay then cancel
        vecs.push_back(mk(1, 2'd2, 0, 0, 0, 0, 3, 0, 0, 0, 0, 0));
        vecs.push_back(mk(1, 2'd0, 1, 0, 0, 0, 3, 0, 0, 0, 0, 0));
        vecs.push_back(mk(1, 2'd0, 0, 1, 0, 0, 3, 0, 1, 0, 0, 1));
        vecs.push_back(mk(1, 2'd0, 1, 0, 1, 0, 3, 0, 1, 0, 0, 1));
        vecs.push_back(mk(1, 2'd0, 0, 0, 0, 1, 2, 0, 1, 0, 0, 1));
        vecs.push_back(mk(1, 2'd0, 0, 0, 0, 0, 2, 0, 1, 0, 0, 1));
        vecs.push_back(mk(1, 2'd0, 0, 0, 0, 1, 1, 0, 1, 0, 0, 1));
        vecs.push_back(mk(1, 2'd0, 0, 0, 0, 1, 0, 0, 0, 0, 0, 0));
        vecs.push_back(mk(1, 2'd0, 0, 0, 0, 1, 0, 0, 0, 0, 0, 0));
        vecs.push_back(mk(1, 2'd2, 0, 0, 0, 0, 2, 0, 0, 0, 0, 0)); // simultaneous inputs
        vecs.push_back(mk(1, 2'd2, 1, 1, 0, 0, 4, 0, 1, 0, 0, 1));
        for (int i = 3; i >= 0; i--)
            vecs.push_back(mk(1, 2'd0, 0, 0, 0, 1, 5'(i), 0, i != 0, 0, 0, i != 0));
        for (int i = 0; i < vecs.size(); i++)
            apply(vecs[i], $sformatf("vec%0d", i));

        apply(mk(1, 2'd3, 0, 0, 0, 0, 5, 0, 0, 0, 0, 0), "rst_disp_load");
        apply(mk(1, 2'd0, 1, 0, 0, 0, 1, 1, 0, 0, 0, 1), "rst_disp_vend");
        apply(mk(0, 2'd3, 1, 1, 1, 0, 0, 0, 0, 0, 0, 0), "rst_disp_reset");
        apply(mk(1, 2'd3, 0, 0, 0, 0, 5, 0, 0, 0, 0, 0), "rst_disp_quarter");
        apply(mk(1, 2'd0, 0, 1, 0, 0, 5, 0, 1, 0, 0, 1), "rst_chg_cancel");
        apply(mk(0, 2'd0, 0, 0, 0, 1, 0, 0, 0, 0, 0, 0), "rst_chg_reset");
        apply(mk(1, 2'd0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0), "rst_chg_idle");

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule

// File: doc/vend_controller.md
VEND_CONTROLLER -- requirements
Module: vend_controller

Interface
REQ-001 SHALL have parameter PRICE, default 4, item price in nickel units.
REQ-002 SHALL have parameter MAX_CREDIT, default 31, maximum credit held, in nickel units.
REQ-003 SHALL have parameter CW, default 5, credit width; MAX_CREDIT SHALL be < 2^CW and PRICE SHALL be in 1..MAX_CREDIT.
REQ-004 SHALL have port clk  in  1  sole clock, rising edge.
REQ-005 SHALL have port reset  in  1  synchronous, active-low reset.
REQ-006 SHALL have port coin  in  2  per-cycle coin event: 00 none, 01 nickel (1 unit), 10 dime (2), 11 quarter (5).
REQ-007 SHALL have port vend_req  in  1  purchase request, sampled each cycle.
REQ-008 SHALL have port cancel  in  1  refund request, sampled each cycle.
REQ-009 SHALL have port dispense_ack  in  1  dispenser has delivered the item.
REQ-010 SHALL have port change_ack  in  1  one nickel ejected.
REQ-011 SHALL have port dispense  out  1  dispense item, held until acknowledged.
REQ-012 SHALL have port change_out  out  1  eject one nickel, held until acknowledged.
REQ-013 SHALL have port coin_reject  out  1  one-cycle pulse: last coin refused.
REQ-014 SHALL have port vend_done  out  1  one-cycle pulse: item delivered.
REQ-015 SHALL have port credit  out  CW  current credit, in nickel units.
REQ-016 SHALL have port busy  out  1  high when the state is not IDLE.

Function
REQ-017 SHALL register all outputs, with no combinational input-to-output paths.
REQ-018 SHALL implement states IDLE, DISPENSE and CHANGE.
REQ-019 IDLE, in priority order cancel > vend_req > coin alone, SHALL do the following:
- cancel with credit+coin > 0 -> CHANGE, any same-cycle coin added to credit; cancel with zero credit and no coin -> no effect.
- vend_req with credit+coin >= PRICE -> credit <= credit+coin-PRICE, DISPENSE.
- vend_req with credit+coin < PRICE -> vend_req ignored, coin accepted normally.
- coin alone -> credit <= credit+value.
REQ-020 SHALL refuse any coin that would make credit exceed MAX_CREDIT: credit unchanged, coin_reject=1 the next cycle, in any IDLE branch; any refused same-cycle coin SHALL not count toward cancel or vend evaluation.
REQ-021 SHALL refuse every coin in DISPENSE and CHANGE (coin_reject pulse, credit unchanged).
REQ-022 In DISPENSE, dispense SHALL be 1 from the first cycle in the state until the cycle dispense_ack is sampled high.
REQ-023 On dispense_ack, SHALL go to CHANGE if credit > 0, else to IDLE, with vend_done=1 for one cycle.
REQ-024 In CHANGE, change_out SHALL be 1; each cycle with change_ack=1 SHALL decrement credit by 1.
REQ-025 On the ack that takes credit to 0, SHALL return to IDLE with change_out deasserted in the next cycle.
REQ-026 SHALL ignore vend_req and cancel outside IDLE, and SHALL ignore dispense_ack outside DISPENSE and change_ack outside CHANGE.
REQ-027 Latency: vend_req or cancel -> dispense or change_out high at the next rising edge.
REQ-028 Credit arithmetic SHALL use CW+1 bits internally and SHALL never wrap.

Reset
REQ-029 With reset=0 at a rising edge, the state SHALL go to IDLE and credit, dispense, change_out, coin_reject, vend_done and busy SHALL all be 0.
REQ-030 Reset SHALL take effect in any state, including mid-DISPENSE or mid-CHANGE; outstanding credit SHALL be discarded and no pulse SHALL be emitted.
REQ-031 Reset SHALL take precedence over all inputs in the same cycle.

Verification
REQ-032 The bench SHALL cover exact payment: 4 nickels then vend_req -> dispense=1 next cycle with credit=0; dispense_ack -> vend_done pulse, IDLE, change_out never high.
REQ-033 The bench SHALL cover payment with change: quarter then vend_req -> credit=1 with dispense=1; dispense_ack -> CHANGE with change_out=1; change_ack held low 3 cycles -> credit stays 1; change_ack -> credit=0, IDLE.
REQ-034 The bench SHALL cover overflow: credit=30 with a dime -> coin_reject=1 for one cycle and credit stays 30; a nickel then -> credit=31.
REQ-035 The bench SHALL cover underpay and cancel: credit=3 with vend_req -> no dispense, credit 3; cancel -> exactly 3 change_ack handshakes, then IDLE with credit=0.
REQ-036 The bench SHALL cover simultaneous inputs: credit=2 with dime, vend_req and cancel in one cycle -> CHANGE with credit=4, no dispense.
REQ-037 The bench SHALL cover reset mid-operation: reset=0 while dispense=1 -> next edge all outputs 0 and credit 0; after release, a quarter -> credit=5.
